// File: rtl/nes_pad_reader.sv
// NES serial gamepad poller: latches/clocks the pad once per poll frame and registers a priority-encoded button code.
// Optional code debouncing is built in when NES_PAD_READER_DEBOUNCE_EN is defined.
module nes_pad_reader #(
  parameter int unsigned POLL_INTERVAL = 833333,
  parameter int unsigned LATCH_CYCLES  = 600,
  parameter int unsigned HALF_CYCLES   = 300
`ifdef NES_PAD_READER_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_FRAMES = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_pulse,
  output logic [3:0] code_out,
  output logic [7:0] buttons,
  output logic       frame_done
);

  localparam int unsigned PW  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam int unsigned PHW = $clog2((LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_LOW, S_HIGH, S_DONE} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  poll_cnt;
  logic           poll_wrap;
  logic [PHW-1:0] phase, phase_next;
  logic [2:0]     bit_idx, bit_idx_next;
  logic [7:0]     shift, shift_next;
  logic           sync1, sync2;
  logic           capture;
  logic [3:0]     code_enc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pad_data;
      sync2 <= sync1;
    end
  end

  assign poll_wrap = (poll_cnt == PW'(POLL_INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (reset || poll_wrap) poll_cnt <= '0;
    else                    poll_cnt <= poll_cnt + 1'b1;
  end

  always_comb begin
    state_next   = state;
    phase_next   = phase + 1'b1;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    capture      = 1'b0;
    pad_latch    = 1'b0;
    pad_pulse    = 1'b0;
    frame_done   = 1'b0;
    case (state)
      S_IDLE: begin
        phase_next = '0;
        if (poll_wrap) state_next = S_LATCH;
      end
      S_LATCH: begin
        pad_latch = 1'b1;
        if (phase == PHW'(LATCH_CYCLES - 1)) begin
          phase_next   = '0;
          bit_idx_next = '0;
          state_next   = S_LOW;
        end
      end
      S_LOW: begin
        if (phase == PHW'(HALF_CYCLES - 1)) begin
          phase_next          = '0;
          shift_next[bit_idx] = ~sync2;
          if (bit_idx == 3'd7) begin
            state_next = S_DONE;
            capture    = 1'b1;
          end else begin
            state_next = S_HIGH;
          end
        end
      end
      S_HIGH: begin
        pad_pulse = 1'b1;
        if (phase == PHW'(HALF_CYCLES - 1)) begin
          phase_next   = '0;
          bit_idx_next = bit_idx + 1'b1;
          state_next   = S_LOW;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        phase_next = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Highest-index pressed button wins; code is its index plus one.
  always_comb begin
    code_enc = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (shift_next[i]) code_enc = 4'(i + 1);
  end

  // Outputs load on entry to S_DONE (with the final bit merged in), so they are
  // already valid during the single frame_done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      buttons <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      if (capture) buttons <= shift_next;
    end
  end

`ifdef NES_PAD_READER_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [3:0]    cand, cand_next;
  logic [DW-1:0] match_cnt, match_next;

  always_comb begin
    cand_next  = cand;
    match_next = match_cnt;
    if (code_enc == cand) begin
      if (match_cnt != DW'(DEBOUNCE_FRAMES)) match_next = match_cnt + 1'b1;
    end else begin
      cand_next  = code_enc;
      match_next = DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand      <= '0;
      match_cnt <= '0;
      code_out  <= '0;
    end else if (capture) begin
      cand      <= cand_next;
      match_cnt <= match_next;
      if (match_next == DW'(DEBOUNCE_FRAMES)) code_out <= cand_next;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset)        code_out <= '0;
    else if (capture) code_out <= code_enc;
  end
`endif

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural NES pad model plus a frame-level reference for buttons/code_out.
module tb_nes_pad_reader;

  localparam int P = 64;
  localparam int L = 4;
  localparam int H = 2;
`ifdef NES_PAD_READER_DEBOUNCE_EN
  localparam int DF = 2;
`else
  localparam int DF = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad_data;
  logic       pad_latch, pad_pulse, frame_done;
  logic [3:0] code_out;
  logic [7:0] buttons;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  pressed = 8'h00;
  int          pad_mode = 0;  // 0 = pad model, 1 = stuck high (unplugged), 2 = stuck low
  int unsigned pad_idx = 0;

  logic [3:0] exp_code = 4'h0;
  logic [3:0] hist[$];

  nes_pad_reader #(
    .POLL_INTERVAL(P),
    .LATCH_CYCLES(L),
    .HALF_CYCLES(H)
`ifdef NES_PAD_READER_DEBOUNCE_EN
    , .DEBOUNCE_FRAMES(DF)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_pulse(pad_pulse),
    .code_out(code_out),
    .buttons(buttons),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Pad: latch reloads to button A, each pulse rising edge advances one button.
  always @(posedge pad_latch or posedge pad_pulse) begin
    if (pad_latch) pad_idx <= 0;
    else           pad_idx <= pad_idx + 1;
  end

  always_comb begin
    case (pad_mode)
      1:       pad_data = 1'b1;
      2:       pad_data = 1'b0;
      default: pad_data = (pad_idx < 8) ? ~pressed[pad_idx[2:0]] : 1'b0;
    endcase
  end

  function automatic logic [3:0] ref_code(input logic [7:0] m);
    for (int i = 7; i >= 0; i--)
      if (m[i]) return 4'(i + 1);
    return 4'h0;
  endfunction

  // code_out follows a code once it has been seen DF frames in a row.
  task automatic model_frame(input logic [7:0] m);
    bit same;
    hist.push_back(ref_code(m));
    if (hist.size() > DF) void'(hist.pop_front());
    if (hist.size() == DF) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same) exp_code = hist[0];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    hist.delete();
    exp_code = 4'h0;
  endtask

  task automatic wait_fd(output int n, output bit ok);
    ok = 1'b0;
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) begin
        n = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (pad_latch !== 1'b0) begin mismatched++; $display("FAIL reset_latch got %b want 0", pad_latch); end
    compared++; if (pad_pulse !== 1'b0) begin mismatched++; $display("FAIL reset_pulse got %b want 0", pad_pulse); end
    compared++; if (code_out !== 4'h0) begin mismatched++; $display("FAIL reset_code got %b want 0000", code_out); end
    compared++; if (buttons !== 8'h00) begin mismatched++; $display("FAIL reset_buttons got %h want 00", buttons); end
    compared++; if (frame_done !== 1'b0) begin mismatched++; $display("FAIL reset_fd got %b want 0", frame_done); end
  endtask

  task automatic test_timing();
    logic el, ep, ef;
    int o;
    pad_mode = 0;
    pressed = 8'h00;
    do_reset();
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk);
      #1;
      o  = c - (P + L);
      el = (c >= P) && (c < P + L);
      ep = (o >= 0) && (o < 15 * H) && (((o / H) % 2) == 1);
      ef = (c == P + L + 15 * H);
      compared++; if (pad_latch !== el) begin mismatched++; $display("FAIL timing_latch c=%0d got %b want %b", c, pad_latch, el); end
      compared++; if (pad_pulse !== ep) begin mismatched++; $display("FAIL timing_pulse c=%0d got %b want %b", c, pad_pulse, ep); end
      compared++; if (frame_done !== ef) begin mismatched++; $display("FAIL timing_fd c=%0d got %b want %b", c, frame_done, ef); end
      if (c == P + L + 15 * H) begin
        model_frame(8'h00);
        compared++; if (buttons !== 8'h00) begin mismatched++; $display("FAIL timing_buttons got %h want 00", buttons); end
        compared++; if (code_out !== exp_code) begin mismatched++; $display("FAIL timing_code got %b want %b", code_out, exp_code); end
      end
    end
  endtask

  task automatic frame_check(input string name, input logic [7:0] m, input logic [7:0] want_btn);
    int n;
    bit ok;
    wait_fd(n, ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL %s_timeout got no frame_done want one within 300 cycles", name); end
    model_frame(want_btn);
    compared++; if (buttons !== want_btn) begin mismatched++; $display("FAIL %s_buttons got %h want %h (mask %h)", name, buttons, want_btn, m); end
    compared++; if (code_out !== exp_code) begin mismatched++; $display("FAIL %s_code got %b want %b", name, code_out, exp_code); end
  endtask

  task automatic test_left();
    pad_mode = 0;
    pressed = 8'h40;
    do_reset();
    frame_check("left", pressed, 8'h40);
  endtask

  task automatic test_multi();
    pressed = 8'hC1;
    frame_check("multi", pressed, 8'hC1);
    pressed = 8'h08;
    frame_check("start", pressed, 8'h08);
  endtask

  task automatic test_stuck();
    pad_mode = 2;
    frame_check("stuck0", 8'hFF, 8'hFF);
    frame_check("stuck0b", 8'hFF, 8'hFF);
    pad_mode = 1;
    frame_check("stuck1", 8'h00, 8'h00);
    frame_check("stuck1b", 8'h00, 8'h00);
    pad_mode = 0;
  endtask

  task automatic test_mid_reset();
    pad_mode = 0;
    pressed = 8'h08;
    do_reset();
    for (int c = 1; c <= 146; c++) begin
      @(posedge clk);
      #1;
      if (c == P + L + 15 * H) begin
        model_frame(8'h08);
        compared++; if (buttons !== 8'h08) begin mismatched++; $display("FAIL midrst_pre_buttons got %h want 08", buttons); end
      end
    end
    compared++; if (pad_pulse !== 1'b1) begin mismatched++; $display("FAIL midrst_in_high got %b want 1", pad_pulse); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    compared++; if (pad_latch !== 1'b0) begin mismatched++; $display("FAIL midrst_latch got %b want 0", pad_latch); end
    compared++; if (pad_pulse !== 1'b0) begin mismatched++; $display("FAIL midrst_pulse got %b want 0", pad_pulse); end
    compared++; if (buttons !== 8'h00) begin mismatched++; $display("FAIL midrst_buttons got %h want 00", buttons); end
    compared++; if (code_out !== 4'h0) begin mismatched++; $display("FAIL midrst_code got %b want 0000", code_out); end
    reset = 1'b0;
    hist.delete();
    exp_code = 4'h0;
    for (int c = 1; c <= P; c++) begin
      @(posedge clk);
      #1;
      if (c == P - 1) begin
        compared++; if (pad_latch !== 1'b0) begin mismatched++; $display("FAIL midrst_early_latch got %b want 0", pad_latch); end
      end
    end
    compared++; if (pad_latch !== 1'b1) begin mismatched++; $display("FAIL midrst_relatch got %b want 1", pad_latch); end
    frame_check("midrst_frame", pressed, 8'h08);
  endtask

  task automatic test_random();
    int n;
    bit ok;
    logic [7:0] m;
    pad_mode = 0;
    pressed = 8'h00;
    do_reset();
    frame_check("rand_sync", 8'h00, 8'h00);
    for (int k = 0; k < 12; k++) begin
      m = (k % 4 == 3) ? 8'h00 : 8'($urandom_range(0, 255));
      if (k % 3 == 1) m = 8'(1 << $urandom_range(0, 7));
      pressed = m;
      wait_fd(n, ok);
      compared++; if (!ok || n != P) begin mismatched++; $display("FAIL rand_period got %0d want %0d", n, P); end
      model_frame(m);
      compared++; if (buttons !== m) begin mismatched++; $display("FAIL rand_buttons got %h want %h", buttons, m); end
      compared++; if (code_out !== exp_code) begin mismatched++; $display("FAIL rand_code got %b want %b (mask %h)", code_out, exp_code, m); end
    end
  endtask

`ifdef NES_PAD_READER_DEBOUNCE_EN
  task automatic test_debounce();
    int n;
    bit ok;
    logic [7:0] seq[3];
    logic [3:0] want[3];
    seq  = '{8'h80, 8'h40, 8'h40};
    want = '{4'h0, 4'h0, 4'h7};
    pad_mode = 0;
    pressed = seq[0];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pressed = seq[k];
      wait_fd(n, ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL deb_timeout frame %0d got none want frame_done", k); end
      compared++; if (buttons !== seq[k]) begin mismatched++; $display("FAIL deb_buttons frame %0d got %h want %h", k, buttons, seq[k]); end
      compared++; if (code_out !== want[k]) begin mismatched++; $display("FAIL deb_code frame %0d got %b want %b", k, code_out, want[k]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_left();
    test_multi();
    test_stuck();
    test_mid_reset();
    test_random();
`ifdef NES_PAD_READER_DEBOUNCE_EN
    test_debounce();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
Upstream stage of the grid controller. It polls an NES-style serial gamepad, deserialises the 8 active-low button bits and priority-encodes them into the 4-bit button code consumed as controller_in. The output is registered and changes only once per poll frame, so the grid controller sees a stable code between frames.

Parameters:
POLL_INTERVAL, 833333, clk cycles between frame starts (60 Hz at 50 MHz); must exceed LATCH_CYCLES+15*HALF_CYCLES.
LATCH_CYCLES, 600, width of pad_latch high pulse (12 us).
HALF_CYCLES, 300, width of each pad_pulse high phase and each low phase (6 us).
DEBOUNCE_FRAMES, 2, consecutive identical frames required before code_out changes (DEBOUNCE_EN builds only).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
pad_data  in  1  serial data from pad, active-low, asynchronous
pad_latch  out  1  latch strobe to pad
pad_pulse  out  1  shift clock to pad
code_out  out  4  encoded button code, drives grid controller controller_in
buttons  out  8  raw pressed mask, bit0=A, 1=B, 2=SELECT, 3=START, 4=UP, 5=DOWN, 6=LEFT, 7=RIGHT (1=pressed)
frame_done  out  1  one-cycle pulse when buttons/code_out update

Behaviour:
- Reset: clock clk; reset is synchronous and active-high. All outputs are 0 (code_out=4'b0000, buttons=8'h00). The FSM goes to S_IDLE and the poll and phase counters clear. The same applies mid-frame: pad_latch and pad_pulse are low at the first edge after reset, and the partial shift register is discarded.
- Input: pad_data passes through a 2-flop synchroniser. All sampling uses the synchronised value. The stored bit is the inverse (pressed=1).
- Poll counter:
  - Free-running, 0..POLL_INTERVAL-1, then wraps.
  - A frame starts on the wrap cycle. The first pad_latch rise occurs POLL_INTERVAL cycles after reset deasserts.
  - The counter keeps running during a frame.
- FSM states:
  - S_IDLE: latch=0, pulse=0. Go to S_LATCH on poll wrap.
  - S_LATCH: latch=1 for LATCH_CYCLES. Then go to S_LOW with bit_idx=0.
  - S_LOW: latch=0, pulse=0 for HALF_CYCLES. On the last cycle, shift[bit_idx] <= ~sync_data. If bit_idx==7, go to S_DONE; else go to S_HIGH.
  - S_HIGH: pulse=1 for HALF_CYCLES, then bit_idx+1 and go to S_LOW.
  - S_DONE: one cycle. buttons<=shift, code_out<=encode(shift), frame_done=1. Then go to S_IDLE.
- Frame shape: exactly 7 pad_pulse pulses per frame. Frame length is LATCH_CYCLES+15*HALF_CYCLES+1 cycles.
- Encoding: highest-index pressed bit wins.
  - RIGHT=4'b1000, LEFT=4'b0111, DOWN=4'b0110, UP=4'b0101, START=4'b0100, SELECT=4'b0011, B=4'b0010, A=4'b0001.
  - No button pressed gives 4'b0000.
- Boundaries:
  - Pad unplugged (pad_data stuck 1) gives code 0000.
  - Pad data stuck 0 gives code 1000 (RIGHT), buttons=8'hFF.
  - A poll wrap while not in S_IDLE is ignored; that frame is skipped, not queued.
- Phase counters are sized by $clog2 of the larger of LATCH_CYCLES and HALF_CYCLES, plus 1.

Optional Feature:
Macro: NES_PAD_READER_DEBOUNCE_EN.
- Defined:
  - A candidate code and a match counter are held.
  - In S_DONE, if the encoded value equals the candidate, the counter increments, saturating at DEBOUNCE_FRAMES. Otherwise the candidate is replaced and the counter is set to 1.
  - code_out takes the candidate only when the counter reaches DEBOUNCE_FRAMES.
  - buttons and frame_done are unaffected (raw every frame).
  - Reset clears the candidate to 0000 and the counter to 0.
- Undefined: code_out updates every frame directly from the encoder.

Test Plan:
- Timing (POLL_INTERVAL=64, LATCH_CYCLES=4, HALF_CYCLES=2): reset, idle pad (data=1) -> latch rises at cycle 64 for 4 cycles, 7 pulses of 2 cycles, frame_done at cycle 64+4+30, code_out=0000, buttons=00.
- Same params, pad model returns LEFT only (bit6 low) -> buttons=8'h40, code_out=4'b0111 after first frame_done.
- LEFT+RIGHT+A pressed -> buttons=8'hC1, code_out=4'b1000; then only START -> next frame code_out=4'b0100.
- Assert reset during S_HIGH of bit 3 -> next cycle pad_latch=0, pad_pulse=0, outputs 0; next latch exactly 64 cycles after reset release.
- Pad data stuck 0 -> buttons=8'hFF, code_out=4'b1000. Pad data stuck 1 -> 0000.
- DEBOUNCE_EN, DEBOUNCE_FRAMES=2: RIGHT in frame 1, LEFT in frame 2, LEFT in frame 3 -> code_out stays 0000 after frames 1 and 2, becomes 0111 after frame 3.
